// File: rtl/wb_regfile_pkg.sv
// Shared constants for the MIPS write-back stage and register file.
// Holds the address/data widths, the zero-register index and the named registers used in tests.
package wb_regfile_pkg;

    localparam int AW    = 5;
    localparam int WIDTH = 32;
    localparam int NREGS = 1 << AW;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_AT   = 5'd1;
    localparam logic [AW-1:0] REG_V0   = 5'd2;
    localparam logic [AW-1:0] REG_V1   = 5'd3;
    localparam logic [AW-1:0] REG_A1   = 5'd5;
    localparam logic [AW-1:0] REG_A3   = 5'd7;
    localparam logic [AW-1:0] REG_T0   = 5'd8;
    localparam logic [AW-1:0] REG_T1   = 5'd9;
    localparam logic [AW-1:0] REG_T2   = 5'd10;
    localparam logic [AW-1:0] REG_SP   = 5'd29;
    localparam logic [AW-1:0] REG_RA   = 5'd31;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

    function automatic logic is_zero_reg(input logic [AW-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_array.sv
// Raw 2^AW x WIDTH storage: synchronous clear, one write port, two asynchronous read ports.
// Zero-register and bypass rules live in the enclosing write-back stage.
module regfile_array
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH = wb_regfile_pkg::WIDTH,
    parameter int AW    = wb_regfile_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects ALU/load data, commits to the register file,
// serves write-first bypassed reads to ID and counts committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH = wb_regfile_pkg::WIDTH,
    parameter int AW    = wb_regfile_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wregin,
    input  logic             m2regin,
    input  logic [AW-1:0]    RdRtin,
    input  logic [WIDTH-1:0] aluresultin,
    input  logic [WIDTH-1:0] memdatain,
    input  logic [AW-1:0]    rna,
    input  logic [AW-1:0]    rnb,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] wbdata,
    output logic [31:0]      wcount
);

    logic             commit;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] raw_b;
    logic [31:0]      wcount_q;

    // Read port resolution: reset masking beats the zero rule, which beats the bypass.
    function automatic logic [WIDTH-1:0] read_port(
        input logic             rst_i,
        input logic [AW-1:0]    addr,
        input logic             wen,
        input logic [AW-1:0]    waddr,
        input logic [WIDTH-1:0] wval,
        input logic [WIDTH-1:0] stored
    );
        if (rst_i || addr == '0) begin
            return '0;
        end else if (wen && waddr == addr) begin
            return wval;
        end else begin
            return stored;
        end
    endfunction

    assign wbdata = (wb_sel_e'(m2regin) == WB_SEL_MEM) ? memdatain : aluresultin;
    assign commit = !rst && wregin && (RdRtin != '0);

    regfile_array #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .waddr   (RdRtin),
        .wdata   (wbdata),
        .raddr_a (rna),
        .raddr_b (rnb),
        .rdata_a (raw_a),
        .rdata_b (raw_b)
    );

    assign qa = read_port(rst, rna, wregin, RdRtin, wbdata, raw_a);
    assign qb = read_port(rst, rnb, wregin, RdRtin, wbdata, raw_b);

    // Wraps naturally modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcount_q <= '0;
        end else if (commit) begin
            wcount_q <= wcount_q + 32'd1;
        end
    end

    assign wcount = wcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             wregin;
    logic             m2regin;
    logic [AW-1:0]    RdRtin;
    logic [WIDTH-1:0] aluresultin;
    logic [WIDTH-1:0] memdatain;
    logic [AW-1:0]    rna;
    logic [AW-1:0]    rnb;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] wbdata;
    logic [31:0]      wcount;

    localparam int SEL_QA = 0, SEL_QB = 1, SEL_WB = 2, SEL_CNT = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wregin      (wregin),
        .m2regin     (m2regin),
        .RdRtin      (RdRtin),
        .aluresultin (aluresultin),
        .memdatain   (memdatain),
        .rna         (rna),
        .rnb         (rnb),
        .qa          (qa),
        .qb          (qb),
        .wbdata      (wbdata),
        .wcount      (wcount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_QA:  return qa;
            SEL_QB:  return qb;
            SEL_WB:  return wbdata;
            default: return wcount;
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = actual(e.sel);
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] val);
        exp_q.push_back('{name, sel, val});
    endtask

    task automatic drive(input logic r, input logic we, input logic m2, input logic [AW-1:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        rst = r; wregin = we; m2regin = m2; RdRtin = rd;
        aluresultin = alu; memdatain = mem; rna = a; rnb = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        drive(1, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_A1, REG_A1);
        step();
        expect_v("reset_qa", SEL_QA, 32'h0);
        expect_v("reset_qb", SEL_QB, 32'h0);
        step();
        expect_v("reset_wcount", SEL_CNT, 32'h0);

        // Write DEADBEEF to r5, then reset for two cycles
        drive(0, 1, 0, REG_A1, 32'hDEADBEEF, 32'h0, REG_A1, REG_ZERO);
        expect_v("r5_bypass", SEL_QA, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, REG_A1, 32'h0, 32'h0, REG_A1, REG_A1);
        expect_v("r5_stored", SEL_QA, 32'hDEADBEEF);
        expect_v("r5_wcount", SEL_CNT, 32'd1);
        step();
        drive(1, 0, 0, REG_A1, 32'h11111111, 32'h0, REG_A1, REG_A1);
        expect_v("rst_mask_qa", SEL_QA, 32'h0);
        expect_v("rst_mask_qb", SEL_QB, 32'h0);
        expect_v("rst_wbdata_live", SEL_WB, 32'h11111111);
        step();
        drive(1, 1, 0, REG_A1, 32'h22222222, 32'h0, REG_A1, REG_A1);
        expect_v("rst_mask_bypass_qa", SEL_QA, 32'h0);
        expect_v("rst_wcount_zero", SEL_CNT, 32'h0);
        step();
        drive(0, 0, 0, REG_A1, 32'h0, 32'h0, REG_A1, REG_A1);
        expect_v("r5_after_rst", SEL_QA, 32'h0);
        expect_v("wcount_after_rst", SEL_CNT, 32'h0);
        step();

        // Mux and commit: ALU to r8, memory to r9
        drive(0, 1, 0, REG_T0, 32'h12345678, 32'hCAFEF00D, REG_ZERO, REG_ZERO);
        expect_v("mux_alu", SEL_WB, 32'h12345678);
        step();
        drive(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_T0, REG_ZERO);
        expect_v("r8_stored", SEL_QA, 32'h12345678);
        expect_v("wcount_1", SEL_CNT, 32'd1);
        step();
        drive(0, 1, 1, REG_T1, 32'h12345678, 32'hCAFEF00D, REG_ZERO, REG_ZERO);
        expect_v("mux_mem", SEL_WB, 32'hCAFEF00D);
        step();
        drive(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_T0, REG_T1);
        expect_v("r9_stored", SEL_QB, 32'hCAFEF00D);
        expect_v("r8_kept", SEL_QA, 32'h12345678);
        expect_v("wcount_2", SEL_CNT, 32'd2);
        step();

        // Bypass: seed r3, then a non-writing and a writing cycle with both ports on r3
        drive(0, 1, 0, REG_V1, 32'h0BADF00D, 32'h0, REG_ZERO, REG_ZERO);
        step();
        drive(0, 0, 0, REG_V1, 32'hA5A5A5A5, 32'h0, REG_V1, REG_V1);
        expect_v("nobypass_qa", SEL_QA, 32'h0BADF00D);
        expect_v("nobypass_qb", SEL_QB, 32'h0BADF00D);
        expect_v("wcount_3", SEL_CNT, 32'd3);
        step();
        drive(0, 1, 0, REG_V1, 32'hA5A5A5A5, 32'h0, REG_V1, REG_V1);
        expect_v("bypass_qa", SEL_QA, 32'hA5A5A5A5);
        expect_v("bypass_qb", SEL_QB, 32'hA5A5A5A5);
        step();
        drive(0, 1, 1, REG_T2, 32'h0, 32'h77777777, REG_T0, REG_V1);
        expect_v("other_rd_qa", SEL_QA, 32'h12345678);
        expect_v("r3_stored_qb", SEL_QB, 32'hA5A5A5A5);
        expect_v("wcount_4", SEL_CNT, 32'd4);
        step();

        // Zero register
        drive(0, 1, 0, REG_ZERO, 32'hFFFFFFFF, 32'h0, REG_ZERO, REG_ZERO);
        expect_v("r0_bypass_qa", SEL_QA, 32'h0);
        expect_v("r0_bypass_qb", SEL_QB, 32'h0);
        expect_v("r0_wbdata", SEL_WB, 32'hFFFFFFFF);
        step();
        drive(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_ZERO, REG_T2);
        expect_v("r0_after", SEL_QA, 32'h0);
        expect_v("r10_stored", SEL_QB, 32'h77777777);
        expect_v("wcount_r0_unchanged", SEL_CNT, 32'd5);
        step();

        // Reset concurrent with a write to r7
        drive(1, 1, 0, REG_A3, 32'h55, 32'h0, REG_A3, REG_A3);
        expect_v("rstwr_qa", SEL_QA, 32'h0);
        step();
        drive(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_A3, REG_T0);
        expect_v("r7_dropped", SEL_QA, 32'h0);
        expect_v("r8_cleared", SEL_QB, 32'h0);
        expect_v("rstwr_wcount", SEL_CNT, 32'h0);
        step();

        // Counter wrap via bench-only preload
        force dut.wcount_q = 32'hFFFFFFFF;
        #1;
        release dut.wcount_q;
        drive(0, 1, 0, REG_SP, 32'h1, 32'h0, REG_ZERO, REG_ZERO);
        expect_v("preload_wcount", SEL_CNT, 32'hFFFFFFFF);
        step();
        drive(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_SP, REG_ZERO);
        expect_v("wrap_wcount", SEL_CNT, 32'h0);
        expect_v("sp_stored", SEL_QA, 32'h1);
        step();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
